// File: rtl/ripple_count_sampler.sv
// Samples the raw outputs of an asynchronous ripple down counter, filters ripple transients,
// tracks the settled count and flags any settled transition that is not a decrement-by-one.
module ripple_count_sampler #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 3,
    parameter int unsigned WRAP_CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      q_in,
    input  logic                  clr_err,
    output logic [WIDTH-1:0]      count,
    output logic                  count_valid,
    output logic                  step_pulse,
    output logic                  wrap_pulse,
    output logic [WRAP_CNT_W-1:0] wrap_count,
    output logic                  seq_err
);

    localparam int unsigned RunW = $clog2(STABLE_CYCLES + 1);
    localparam logic [RunW-1:0] RunMax = RunW'(STABLE_CYCLES);

    typedef enum logic [1:0] {StAcquire, StTrack, StError} state_e;

    logic [WIDTH-1:0]      sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]      sync_d [SYNC_STAGES];
    logic [WIDTH-1:0]      cand_q, cand_d;
    logic [RunW-1:0]       run_q, run_d;
    state_e                state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic                  valid_q, valid_d;
    logic                  step_q, step_d;
    logic                  wrap_q, wrap_d;
    logic [WRAP_CNT_W-1:0] wcnt_q, wcnt_d;
    logic                  err_q, err_d;

    logic [WIDTH-1:0]      s;
    logic                  stable;
    logic [WIDTH-1:0]      count_dec;

    assign s         = sync_q[SYNC_STAGES-1];
    assign stable    = (run_q == RunMax);
    assign count_dec = count_q - {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        sync_d[0] = q_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Run length of identical synchronised samples, saturating once settled.
    always_comb begin
        cand_d = cand_q;
        run_d  = run_q;
        if (s == cand_q) begin
            if (run_q != RunMax) begin
                run_d = run_q + RunW'(1);
            end
        end else begin
            cand_d = s;
            run_d  = RunW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        valid_d = valid_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        unique case (state_q)
            StAcquire: begin
                if (stable) begin
                    count_d = cand_q;
                    valid_d = 1'b1;
                    state_d = StTrack;
                end
            end
            StTrack: begin
                if (stable && (cand_q != count_q)) begin
                    count_d = cand_q;
                    if (cand_q == count_dec) begin
                        step_d = 1'b1;
                        if (count_q == '0) begin
                            wrap_d = 1'b1;
                            wcnt_d = wcnt_q + {{(WRAP_CNT_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        err_d   = 1'b1;
                        valid_d = 1'b0;
                        state_d = StError;
                    end
                end
            end
            StError: begin
                valid_d = 1'b0;
                // Clearing wins over a same-cycle settled update; re-acquire relocks next edge.
                if (clr_err) begin
                    err_d   = 1'b0;
                    state_d = StAcquire;
                end else if (stable) begin
                    count_d = cand_q;
                end
            end
            default: state_d = StAcquire;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            cand_q  <= '0;
            run_q   <= '0;
            state_q <= StAcquire;
            count_q <= '0;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            cand_q  <= cand_d;
            run_q   <= run_d;
            state_q <= state_d;
            count_q <= count_d;
            valid_q <= valid_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    assign count       = count_q;
    assign count_valid = valid_q;
    assign step_pulse  = step_q;
    assign wrap_pulse  = wrap_q;
    assign wrap_count  = wcnt_q;
    assign seq_err     = err_q;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Directed self-checking bench for ripple_count_sampler (wrap tally narrowed to 2 bits).
module tb_ripple_count_sampler;

    logic       clk;
    logic       rst_n;
    logic [3:0] q_in;
    logic       clr_err;
    logic [3:0] count;
    logic       count_valid;
    logic       step_pulse;
    logic       wrap_pulse;
    logic [1:0] wrap_count;
    logic       seq_err;

    int checks;
    int errors;
    int step_seen;
    int wrap_seen;
    int wrap_alone;

    ripple_count_sampler #(
        .WIDTH         (4),
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (3),
        .WRAP_CNT_W    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .q_in        (q_in),
        .clr_err     (clr_err),
        .count       (count),
        .count_valid (count_valid),
        .step_pulse  (step_pulse),
        .wrap_pulse  (wrap_pulse),
        .wrap_count  (wrap_count),
        .seq_err     (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (step_pulse) step_seen++;
            if (wrap_pulse) wrap_seen++;
            if (wrap_pulse && !step_pulse) wrap_alone++;
        end
    end

    // Drive a value for n clock edges; starts and ends just after a rising edge.
    task automatic hold(input logic [3:0] v, input int n);
        q_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_seen();
        step_seen  = 0;
        wrap_seen  = 0;
        wrap_alone = 0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        q_in    = 4'hF;
        clr_err = 1'b0;
        clear_seen();
        #12;
        checks++;
        if ({count, count_valid, step_pulse, wrap_pulse, wrap_count, seq_err} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got count=%h valid=%b step=%b wrap=%b wc=%0d err=%b, want all 0",
                     count, count_valid, step_pulse, wrap_pulse, wrap_count, seq_err);
        end
    endtask

    task automatic test_acquire();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (count_valid !== 1'b0) begin
            errors++;
            $display("FAIL acquire_early: count_valid=%b after 5 edges, want 0", count_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (count_valid !== 1'b1 || count !== 4'hF) begin
            errors++;
            $display("FAIL acquire_lock: valid=%b count=%h after 6 edges, want 1/F",
                     count_valid, count);
        end
        hold(4'hF, 4);
        checks++;
        if (step_seen !== 0 || wrap_seen !== 0 || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL acquire_quiet: steps=%0d wraps=%0d err=%b, want 0/0/0",
                     step_seen, wrap_seen, seq_err);
        end
    endtask

    task automatic test_full_sequence();
        clear_seen();
        for (int v = 14; v >= 0; v--) hold(4'(v), 10);
        hold(4'hF, 10);
        checks++;
        if (step_seen !== 16) begin
            errors++;
            $display("FAIL full_steps: step pulses=%0d, want 16", step_seen);
        end
        checks++;
        if (wrap_seen !== 1 || wrap_alone !== 0) begin
            errors++;
            $display("FAIL full_wrap_pulse: wraps=%0d uncoincident=%0d, want 1/0",
                     wrap_seen, wrap_alone);
        end
        checks++;
        if (wrap_count !== 2'd1 || seq_err !== 1'b0 || count !== 4'hF) begin
            errors++;
            $display("FAIL full_state: wc=%0d err=%b count=%h, want 1/0/F",
                     wrap_count, seq_err, count);
        end
    endtask

    task automatic test_glitches();
        for (int v = 14; v >= 8; v--) hold(4'(v), 10);
        clear_seen();
        hold(4'h9, 1);
        hold(4'hB, 1);
        hold(4'hF, 1);
        hold(4'h7, 10);
        checks++;
        if (step_seen !== 1 || count !== 4'h7 || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL glitch_filter: steps=%0d count=%h err=%b, want 1/7/0",
                     step_seen, count, seq_err);
        end
    endtask

    task automatic test_illegal_skip();
        hold(4'h6, 10);
        hold(4'h5, 10);
        clear_seen();
        hold(4'h3, 10);
        checks++;
        if (seq_err !== 1'b1 || count_valid !== 1'b0 || count !== 4'h3 || step_seen !== 0) begin
            errors++;
            $display("FAIL skip_error: err=%b valid=%b count=%h steps=%0d, want 1/0/3/0",
                     seq_err, count_valid, count, step_seen);
        end
        hold(4'h1, 10);
        checks++;
        if (count !== 4'h1 || seq_err !== 1'b1 || count_valid !== 1'b0) begin
            errors++;
            $display("FAIL error_follow: count=%h err=%b valid=%b, want 1/1/0",
                     count, seq_err, count_valid);
        end
        hold(4'h3, 10);
        clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        checks++;
        if (seq_err !== 1'b0 || count_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_err: err=%b valid=%b, want 0/0", seq_err, count_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (count_valid !== 1'b1 || count !== 4'h3) begin
            errors++;
            $display("FAIL reacquire: valid=%b count=%h, want 1/3", count_valid, count);
        end
        clear_seen();
        hold(4'h2, 10);
        checks++;
        if (step_seen !== 1 || count !== 4'h2 || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL post_clear_step: steps=%0d count=%h err=%b, want 1/2/0",
                     step_seen, count, seq_err);
        end
    endtask

    task automatic test_reset_mid();
        hold(4'h1, 10);
        hold(4'h0, 10);
        for (int v = 15; v >= 6; v--) hold(4'(v), 10);
        checks++;
        if (wrap_count !== 2'd2 || count !== 4'h6 || count_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: wc=%0d count=%h valid=%b, want 2/6/1",
                     wrap_count, count, count_valid);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({count, count_valid, step_pulse, wrap_pulse, wrap_count, seq_err} !== 10'd0) begin
            errors++;
            $display("FAIL async_reset: count=%h valid=%b step=%b wrap=%b wc=%0d err=%b, want 0",
                     count, count_valid, step_pulse, wrap_pulse, wrap_count, seq_err);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (count_valid !== 1'b0) begin
            errors++;
            $display("FAIL reacq_early: count_valid=%b after 5 edges, want 0", count_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (count_valid !== 1'b1 || count !== 4'h6 || wrap_count !== 2'd0) begin
            errors++;
            $display("FAIL reacq_lock: valid=%b count=%h wc=%0d, want 1/6/0",
                     count_valid, count, wrap_count);
        end
    endtask

    task automatic test_wrap_rollover();
        logic [1:0] exp_wc;
        exp_wc = 2'd0;
        clear_seen();
        for (int v = 5; v >= 0; v--) hold(4'(v), 10);
        for (int w = 0; w < 4; w++) begin
            hold(4'hF, 10);
            exp_wc = exp_wc + 2'd1;
            checks++;
            if (wrap_count !== exp_wc) begin
                errors++;
                $display("FAIL wrap_count_%0d: got %0d, want %0d", w, wrap_count, exp_wc);
            end
            for (int v = 14; v >= 0; v--) hold(4'(v), 10);
        end
        checks++;
        if (wrap_seen !== 4 || wrap_alone !== 0 || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL rollover_pulses: wraps=%0d uncoincident=%0d err=%b, want 4/0/0",
                     wrap_seen, wrap_alone, seq_err);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_acquire();
        test_full_sequence();
        test_glitches();
        test_illegal_skip();
        test_reset_mid();
        test_wrap_rollover();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
